// File: rtl/rx_data.sv
// Serial byte receiver: start(0), 8 data bits MSB first, stop(1). Delivers bytes on a
// valid/ready output register and flags framing errors and overruns.
module rx_data #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned SYNC_STAGES  = 0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned SampleInt = (CLKS_PER_BIT - 1) / 2;
  localparam logic [9:0]  SamplePt  = 10'(SampleInt);
  localparam logic [9:0]  LastCnt   = 10'(CLKS_PER_BIT - 1);
  // Baud offset of the edge following E0
  localparam logic [9:0]  FirstInc  = (LastCnt == 10'd0) ? 10'd0 : 10'd1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic       s;
  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       framing_err_q, framing_err_d;
  logic       overrun_q, overrun_d;
  logic       at_sample;
  logic       load;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = rx_in;
    end else begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_in};
      end
      assign s = sync_q[1];
    end
  endgenerate

  assign cnt_inc   = (cnt_q == LastCnt) ? 10'd0 : cnt_q + 10'd1;
  assign at_sample = (cnt_q == SamplePt);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_inc;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    load          = 1'b0;
    framing_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 10'd0;
        if (!s) begin
          cnt_d     = FirstInc;
          bit_cnt_d = 4'd0;
          // With a zero sample point the E0 sample is itself the start sample
          state_d   = (SamplePt == 10'd0) ? StData : StStart;
        end
      end
      StStart: begin
        if (at_sample) state_d = s ? StIdle : StData;
      end
      StData: begin
        if (at_sample) begin
          shift_d   = {shift_q[6:0], s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (at_sample) begin
          if (s) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            framing_err_d = 1'b1;
            state_d       = StBreak;
          end
        end
      end
      StBreak: begin
        if (s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_byte_d  = load ? shift_q : rx_byte_q;
    rx_valid_d = load | (rx_valid_q & ~rx_ready);
    overrun_d  = load & rx_valid_q & ~rx_ready;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      cnt_q         <= 10'd0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
      rx_byte_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_rx_data.sv
// Randomised scoreboard bench for rx_data: three instances (plain, 4x oversampled,
// synchronised loopback) checked against a byte-level handshake model.
module tb_rx_data;

  localparam int EvOvr  = 256;
  localparam int EvFerr = 512;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_in       [3];
  logic       rx_ready    [3];
  logic [7:0] rx_byte     [3];
  logic       rx_valid    [3];
  logic       framing_err [3];
  logic       overrun     [3];
  logic       rx_busy     [3];

  int         checks = 0;
  int         errors = 0;
  int         exp_q  [3][$];
  logic       pend_v [3];
  logic [7:0] pend_b [3];

  always #5 clk = ~clk;

  rx_data #(.CLKS_PER_BIT(1), .SYNC_STAGES(0)) u_a (
    .clk(clk), .n_rst(n_rst), .rx_in(rx_in[0]), .rx_ready(rx_ready[0]),
    .rx_byte(rx_byte[0]), .rx_valid(rx_valid[0]), .framing_err(framing_err[0]),
    .overrun(overrun[0]), .rx_busy(rx_busy[0])
  );
  rx_data #(.CLKS_PER_BIT(4), .SYNC_STAGES(0)) u_b (
    .clk(clk), .n_rst(n_rst), .rx_in(rx_in[1]), .rx_ready(rx_ready[1]),
    .rx_byte(rx_byte[1]), .rx_valid(rx_valid[1]), .framing_err(framing_err[1]),
    .overrun(overrun[1]), .rx_busy(rx_busy[1])
  );
  rx_data #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_c (
    .clk(clk), .n_rst(n_rst), .rx_in(rx_in[2]), .rx_ready(rx_ready[2]),
    .rx_byte(rx_byte[2]), .rx_valid(rx_valid[2]), .framing_err(framing_err[2]),
    .overrun(overrun[2]), .rx_busy(rx_busy[2])
  );

  function automatic int cpb_of(int i);
    return (i == 1) ? 4 : 1;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Byte-level model: one pending slot per receiver, consumed whenever ready is seen.
  function automatic void model_load(int i, logic [7:0] b, logic rdy);
    if (pend_v[i]) exp_q[i].push_back(rdy ? int'(pend_b[i]) : EvOvr);
    pend_v[i] = 1'b1;
    pend_b[i] = b;
  endfunction

  function automatic void model_consume(int i);
    if (pend_v[i]) exp_q[i].push_back(int'(pend_b[i]));
    pend_v[i] = 1'b0;
  endfunction

  function automatic void model_ferr(int i);
    exp_q[i].push_back(EvFerr);
  endfunction

  task automatic mon_event(int i, int got, string name);
    int e;
    checks++;
    if (exp_q[i].size() == 0) begin
      errors++;
      $display("FAIL unexpected %s dut%0d: got %0d expected none", name, i, got);
    end else begin
      e = exp_q[i].pop_front();
      if (e != got) begin
        errors++;
        $display("FAIL %s dut%0d: got %0d expected %0d", name, i, got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < 3; i++) begin
        if (overrun[i])                 mon_event(i, EvOvr, "overrun");
        if (framing_err[i])             mon_event(i, EvFerr, "framing_err");
        if (rx_valid[i] && rx_ready[i]) mon_event(i, int'(rx_byte[i]), "byte");
      end
    end
  end

  function automatic logic frame_bit(logic [7:0] d, logic stop, int k);
    if (k == 0) return 1'b0;
    if (k == 9) return stop;
    return d[8-k];
  endfunction

  task automatic send_frame(int i, logic [7:0] d, logic stop, logic rdy_on_stop);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < cpb_of(i); c++) begin
        @(posedge clk); #1;
        rx_in[i] = frame_bit(d, stop, k);
        if (k == 9 && c == 0 && rdy_on_stop) rx_ready[i] = 1'b1;
      end
    end
  endtask

  task automatic idle(int i, int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_in[i] = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    for (int i = 0; i < 3; i++) begin
      rx_in[i]    = 1'b1;
      rx_ready[i] = 1'b0;
      pend_v[i]   = 1'b0;
      pend_b[i]   = 8'd0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset valid dut%0d", i), int'(rx_valid[i]), 0);
      check($sformatf("reset byte dut%0d", i), int'(rx_byte[i]), 0);
      check($sformatf("reset busy dut%0d", i), int'(rx_busy[i]), 0);
      check($sformatf("reset ferr dut%0d", i), int'(framing_err[i]), 0);
      check($sformatf("reset ovr dut%0d", i), int'(overrun[i]), 0);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle(0, 2);

    // Clean 0xA5 frame with exact latency and busy window
    model_load(0, 8'hA5, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("clean busy k%0d", k), int'(rx_busy[0]), (k >= 1) ? 1 : 0);
      check($sformatf("clean valid k%0d", k), int'(rx_valid[0]), 0);
      rx_in[0] = frame_bit(8'hA5, 1'b1, k);
    end
    @(posedge clk); #1;
    rx_in[0] = 1'b1;
    check("clean valid after stop", int'(rx_valid[0]), 1);
    check("clean byte", int'(rx_byte[0]), 8'hA5);
    check("clean busy after stop", int'(rx_busy[0]), 0);
    check("clean ferr", int'(framing_err[0]), 0);
    idle(0, 2);
    rx_ready[0] = 1'b1;
    model_consume(0);
    idle(0, 2);

    // Back-to-back with ready held high
    model_load(0, 8'h41, 1'b1); model_consume(0);
    send_frame(0, 8'h41, 1'b1, 1'b0);
    model_load(0, 8'h7A, 1'b1); model_consume(0);
    send_frame(0, 8'h7A, 1'b1, 1'b0);
    idle(0, 3);

    // Back-to-back with ready low: overwrite and overrun
    rx_ready[0] = 1'b0;
    model_load(0, 8'h41, 1'b0);
    send_frame(0, 8'h41, 1'b1, 1'b0);
    model_load(0, 8'h7A, 1'b0);
    send_frame(0, 8'h7A, 1'b1, 1'b0);
    idle(0, 3);
    check("overrun byte", int'(rx_byte[0]), 8'h7A);
    check("overrun valid", int'(rx_valid[0]), 1);
    rx_ready[0] = 1'b1;
    model_consume(0);
    idle(0, 2);

    // Consume on the same edge as a new load
    rx_ready[0] = 1'b0;
    model_load(0, 8'h41, 1'b0);
    send_frame(0, 8'h41, 1'b1, 1'b0);
    model_load(0, 8'h7A, 1'b1); model_consume(0);
    send_frame(0, 8'h7A, 1'b1, 1'b1);
    idle(0, 3);

    // Framing error then a break held for 5 cycles
    model_ferr(0);
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      rx_in[0] = 1'b0;
      check($sformatf("break busy %0d", n), int'(rx_busy[0]), 1);
    end
    @(posedge clk); #1;
    rx_in[0] = 1'b1;
    check("break busy last low", int'(rx_busy[0]), 1);
    @(posedge clk); #1;
    check("break released", int'(rx_busy[0]), 0);
    check("ferr no valid", int'(rx_valid[0]), 0);
    model_load(0, 8'h55, 1'b1); model_consume(0);
    send_frame(0, 8'h55, 1'b1, 1'b0);
    idle(0, 3);

    // Oversampled: 1-cycle glitch is a false start, then a real frame
    idle(1, 2);
    @(posedge clk); #1;
    rx_in[1] = 1'b0;
    @(posedge clk); #1;
    rx_in[1] = 1'b1;
    check("glitch start busy", int'(rx_busy[1]), 1);
    @(posedge clk); #1;
    check("glitch rejected", int'(rx_busy[1]), 0);
    idle(1, 6);
    check("glitch no valid", int'(rx_valid[1]), 0);
    rx_ready[1] = 1'b1;
    model_load(1, 8'hC3, 1'b1); model_consume(1);
    send_frame(1, 8'hC3, 1'b1, 1'b0);
    idle(1, 8);

    // Mid-frame reset with a pending byte
    rx_ready[0] = 1'b0;
    model_load(0, 8'h99, 1'b0);
    send_frame(0, 8'h99, 1'b1, 1'b0);
    idle(0, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      rx_in[0] = frame_bit(8'hFF, 1'b1, k);
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    pend_v[0] = 1'b0;
    #1;
    check("midrst valid", int'(rx_valid[0]), 0);
    check("midrst byte", int'(rx_byte[0]), 0);
    check("midrst busy", int'(rx_busy[0]), 0);
    rx_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    idle(0, 2);
    rx_ready[0] = 1'b1;
    model_load(0, 8'h12, 1'b1); model_consume(0);
    send_frame(0, 8'h12, 1'b1, 1'b0);
    idle(0, 3);

    // Random frames with occasional bad stop bits and gaps
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      if (stop) begin
        model_load(0, b, 1'b1); model_consume(0);
      end else begin
        model_ferr(0);
      end
      send_frame(0, b, stop, 1'b0);
      idle(0, stop ? $urandom_range(0, 2) : $urandom_range(1, 3));
    end
    idle(0, 3);

    // Synchronised loopback of 16 random bytes
    rx_ready[2] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom);
      model_load(2, b, 1'b1); model_consume(2);
      send_frame(2, b, 1'b1, 1'b0);
    end
    idle(2, 10);

    for (int i = 0; i < 3; i++) check($sformatf("leftover dut%0d", i), exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
